// File: rtl/jump_distance_gen_if.sv
// Handshake bundle between game control, the roll counter and jump_distance_gen.
// The generator connects through the slave modport; the controlling side uses master.
interface jump_distance_gen_if #(
    parameter int RAND_WIDTH = 7,
    parameter int OUT_WIDTH  = 8
);
    logic [RAND_WIDTH-1:0] i_random_binary;
    logic                  i_req;
    logic                  i_ack;
    logic                  o_roll;
    logic                  o_busy;
    logic                  o_valid;
    logic [OUT_WIDTH-1:0]  o_distance;

    modport slave (
        input  i_random_binary,
        input  i_req,
        input  i_ack,
        output o_roll,
        output o_busy,
        output o_valid,
        output o_distance
    );

    modport master (
        output i_random_binary,
        output i_req,
        output i_ack,
        input  o_roll,
        input  o_busy,
        input  o_valid,
        input  o_distance
    );
endinterface

// File: rtl/jump_distance_gen.sv
// Reduces a sampled random word into [MIN_VAL, MAX_VAL] by repeated subtraction.
// Optional JUMP_DISTANCE_NO_REPEAT_EN: never deliver the same distance twice in a row.
module jump_distance_gen #(
    parameter int RAND_WIDTH = 7,
    parameter int OUT_WIDTH  = 8,
    parameter int MIN_VAL    = 20,
    parameter int MAX_VAL    = 100
) (
    input  logic               clk_jump_distance_gen,
    input  logic               rst_jump_distance_gen,
    jump_distance_gen_if.slave bus
);
    localparam int AW = ((RAND_WIDTH > OUT_WIDTH) ? RAND_WIDTH : OUT_WIDTH) + 1;
    localparam logic [AW-1:0] RANGE = AW'(MAX_VAL - MIN_VAL + 1);
    localparam logic [AW-1:0] MIN_A = AW'(MIN_VAL);
    localparam logic [OUT_WIDTH-1:0] MIN_O = OUT_WIDTH'(MIN_VAL);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SAMPLE = 2'd1;
    localparam logic [1:0] ST_REDUCE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [AW-1:0]        rem_q, rem_d;
    logic                 valid_q, valid_d;
    logic [OUT_WIDTH-1:0] dist_q, dist_d;
    logic [AW-1:0]        cand_w;
    logic [AW-1:0]        deliver_w;

    assign cand_w = MIN_A + rem_q;

`ifdef JUMP_DISTANCE_NO_REPEAT_EN
    localparam logic [AW-1:0] MAX_A = AW'(MAX_VAL);

    logic [AW-1:0] last_q;
    logic          last_vld_q;

    // Bump a repeat to the next value, wrapping MAX back to MIN; a one-value range cannot avoid repeats.
    always_comb begin
        deliver_w = cand_w;
        if (last_vld_q && (RANGE > AW'(1)) && (cand_w == last_q)) begin
            deliver_w = (cand_w == MAX_A) ? MIN_A : cand_w + AW'(1);
        end
    end

    always_ff @(posedge clk_jump_distance_gen or posedge rst_jump_distance_gen) begin
        if (rst_jump_distance_gen) begin
            last_q     <= '0;
            last_vld_q <= 1'b0;
        end else if (state_q == ST_REDUCE && rem_q < RANGE) begin
            last_q     <= deliver_w;
            last_vld_q <= 1'b1;
        end
    end
`else
    assign deliver_w = cand_w;
`endif

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        valid_d = valid_q;
        dist_d  = dist_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_req) begin
                    rem_d   = {{(AW-RAND_WIDTH){1'b0}}, bus.i_random_binary};
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                state_d = ST_REDUCE;
            end
            ST_REDUCE: begin
                if (rem_q >= RANGE) begin
                    rem_d = rem_q - RANGE;
                end else begin
                    dist_d  = OUT_WIDTH'(deliver_w);
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: begin
                // A simultaneous request is dropped: the requester re-asserts from IDLE.
                if (bus.i_ack) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_jump_distance_gen or posedge rst_jump_distance_gen) begin
        if (rst_jump_distance_gen) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            valid_q <= 1'b0;
            dist_q  <= MIN_O;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
            dist_q  <= dist_d;
        end
    end

    // Roll only while idle so the sampled word stays frozen during reduction.
    assign bus.o_roll     = (state_q == ST_IDLE);
    assign bus.o_busy     = (state_q != ST_IDLE);
    assign bus.o_valid    = valid_q;
    assign bus.o_distance = dist_q;
endmodule
